// File: rtl/miriscv_rvfi_pkg.sv
// miriscv_rvfi_pkg: shared types and constants for the RVFI retirement tracker
// Provides the issue-buffer entry, the registered RVFI packet and the fixed mode/XLEN encodings.
package miriscv_rvfi_pkg;
   localparam logic [1:0] RVFI_MODE_M = 2'b11;
   localparam logic [1:0] RVFI_IXL_32 = 2'b01;
   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
   } rvfi_issue_entry_t;
   typedef struct packed {
      logic        valid;
      logic [63:0] order;
      logic [31:0] insn;
      logic        trap;
      logic        halt;
      logic        intr;
      logic [1:0]  mode;
      logic [1:0]  ixl;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } rvfi_pkt_t;
endpackage

// File: rtl/miriscv_rvfi_tracker_if.sv
// miriscv_rvfi_tracker_if: pipeline-side issue/retire signals and RVFI monitor outputs of the tracker
// master: core pipeline / bench (drives issue_*, retire_*, flush_i, halt_i; sees ready, err, rvfi_*)
// slave : tracker (consumes the pipeline signals, drives issue_ready_o, err_o and every rvfi_* output)
interface miriscv_rvfi_tracker_if;
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic [31:0] issue_insn_i;
   logic [31:0] issue_pc_i;
   logic [4:0]  issue_rs1_addr_i;
   logic [4:0]  issue_rs2_addr_i;
   logic [31:0] issue_rs1_rdata_i;
   logic [31:0] issue_rs2_rdata_i;
   logic        retire_valid_i;
   logic        retire_trap_i;
   logic [4:0]  retire_rd_addr_i;
   logic [31:0] retire_rd_wdata_i;
   logic [31:0] retire_pc_wdata_i;
   logic [31:0] retire_mem_addr_i;
   logic [3:0]  retire_mem_rmask_i;
   logic [3:0]  retire_mem_wmask_i;
   logic [31:0] retire_mem_rdata_i;
   logic [31:0] retire_mem_wdata_i;
   logic        flush_i;
   logic        halt_i;
   logic        err_o;
   logic        rvfi_valid;
   logic [63:0] rvfi_order;
   logic [31:0] rvfi_insn;
   logic        rvfi_trap;
   logic        rvfi_halt;
   logic        rvfi_intr;
   logic [1:0]  rvfi_mode;
   logic [1:0]  rvfi_ixl;
   logic [4:0]  rvfi_rs1_addr;
   logic [4:0]  rvfi_rs2_addr;
   logic [4:0]  rvfi_rs3_addr;
   logic [31:0] rvfi_rs1_rdata;
   logic [31:0] rvfi_rs2_rdata;
   logic [31:0] rvfi_rs3_rdata;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic [31:0] rvfi_pc_rdata;
   logic [31:0] rvfi_pc_wdata;
   logic [31:0] rvfi_mem_addr;
   logic [3:0]  rvfi_mem_rmask;
   logic [3:0]  rvfi_mem_wmask;
   logic [31:0] rvfi_mem_rdata;
   logic [31:0] rvfi_mem_wdata;
   modport master (
      output issue_valid_i, issue_insn_i, issue_pc_i, issue_rs1_addr_i, issue_rs2_addr_i,
             issue_rs1_rdata_i, issue_rs2_rdata_i, retire_valid_i, retire_trap_i, retire_rd_addr_i,
             retire_rd_wdata_i, retire_pc_wdata_i, retire_mem_addr_i, retire_mem_rmask_i,
             retire_mem_wmask_i, retire_mem_rdata_i, retire_mem_wdata_i, flush_i, halt_i,
      input  issue_ready_o, err_o, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
             rvfi_mode, rvfi_ixl, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rs1_rdata,
             rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
   );
   modport slave (
      input  issue_valid_i, issue_insn_i, issue_pc_i, issue_rs1_addr_i, issue_rs2_addr_i,
             issue_rs1_rdata_i, issue_rs2_rdata_i, retire_valid_i, retire_trap_i, retire_rd_addr_i,
             retire_rd_wdata_i, retire_pc_wdata_i, retire_mem_addr_i, retire_mem_rmask_i,
             retire_mem_wmask_i, retire_mem_rdata_i, retire_mem_wdata_i, flush_i, halt_i,
      output issue_ready_o, err_o, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
             rvfi_mode, rvfi_ixl, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rs1_rdata,
             rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
   );
endinterface

// File: rtl/miriscv_rvfi_fifo.sv
// miriscv_rvfi_fifo: in-order synchronous FIFO of DEPTH (power of two) entries of type T
// clk/rst: clock and sync active-high reset; push/pop: enqueue din / dequeue head (caller guards full/empty)
// flush: empties the FIFO, overriding push/pop; dout: head entry; full/empty: occupancy flags
module miriscv_rvfi_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic flush,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   T mem [DEPTH];
   logic [AW-1:0] rp, wp;
   logic [AW:0]   cnt;
   assign dout  = mem[rp];
   assign full  = cnt[AW];
   assign empty = cnt == '0;
   always_ff @(posedge clk)
      if (push && !flush) mem[wp] <= din;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/miriscv_rvfi_tracker.sv
// miriscv_rvfi_tracker: buffers issued instructions in order and emits one registered RVFI packet per retirement
// clk/rst: core clock, sync active-high reset; bus (slave): issue/retire/flush/halt inputs, issue_ready_o,
// sticky err_o and the full rvfi_* monitor signal set.
// MIRISCV_RVFI_MEM_EN: when defined, retire_mem_* pass into rvfi_mem_*; otherwise rvfi_mem_* are 0.
module miriscv_rvfi_tracker
   import miriscv_rvfi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   miriscv_rvfi_tracker_if.slave bus
);
   logic full, empty, push, pop, halted, intr_pend, err_q;
   logic [63:0] order_q;
   rvfi_issue_entry_t entry, head;
   rvfi_pkt_t pkt_q, pkt_d;
   assign bus.issue_ready_o = !full && !bus.flush_i;
   assign push = bus.issue_valid_i && bus.issue_ready_o;
   // the head must already be in the buffer: an entry pushed this edge cannot retire on it
   assign pop = bus.retire_valid_i && !empty && !halted;
   assign entry = '{insn: bus.issue_insn_i, pc: bus.issue_pc_i,
                    rs1_addr: bus.issue_rs1_addr_i, rs2_addr: bus.issue_rs2_addr_i,
                    rs1_rdata: bus.issue_rs1_rdata_i, rs2_rdata: bus.issue_rs2_rdata_i};
   miriscv_rvfi_fifo #(.DEPTH(DEPTH), .T(rvfi_issue_entry_t)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(bus.flush_i),
      .din(entry), .dout(head), .full(full), .empty(empty)
   );
   always_comb begin
      pkt_d       = pkt_q;
      pkt_d.valid = pop;
      if (pop) begin
         pkt_d.order     = order_q;
         pkt_d.insn      = head.insn;
         pkt_d.pc_rdata  = head.pc;
         pkt_d.rs1_addr  = head.rs1_addr;
         pkt_d.rs2_addr  = head.rs2_addr;
         pkt_d.rs1_rdata = head.rs1_rdata;
         pkt_d.rs2_rdata = head.rs2_rdata;
         pkt_d.trap      = bus.retire_trap_i;
         pkt_d.halt      = bus.halt_i;
         pkt_d.intr      = intr_pend;
         pkt_d.mode      = RVFI_MODE_M;
         pkt_d.ixl       = RVFI_IXL_32;
         pkt_d.rd_addr   = bus.retire_rd_addr_i;
         pkt_d.rd_wdata  = bus.retire_rd_addr_i == 5'd0 ? 32'd0 : bus.retire_rd_wdata_i;
         pkt_d.pc_wdata  = bus.retire_pc_wdata_i;
`ifdef MIRISCV_RVFI_MEM_EN
         pkt_d.mem_addr  = bus.retire_mem_addr_i;
         pkt_d.mem_rmask = bus.retire_mem_rmask_i;
         pkt_d.mem_wmask = bus.retire_mem_wmask_i;
         pkt_d.mem_rdata = bus.retire_mem_rdata_i;
         pkt_d.mem_wdata = bus.retire_mem_wdata_i;
`endif
      end
   end
`ifndef MIRISCV_RVFI_MEM_EN
   logic unused_mem;
   assign unused_mem = ^{bus.retire_mem_addr_i, bus.retire_mem_rmask_i, bus.retire_mem_wmask_i,
                         bus.retire_mem_rdata_i, bus.retire_mem_wdata_i};
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_q     <= '0;
         order_q   <= '0;
         intr_pend <= 1'b0;
         halted    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         pkt_q <= pkt_d;
         if (pop) begin
            order_q   <= order_q + 64'd1;
            intr_pend <= bus.retire_trap_i;
            halted    <= bus.halt_i;
         end
         // retire with nothing to retire, or after the halt packet, is a protocol error
         if (bus.retire_valid_i && !pop) err_q <= 1'b1;
      end
   end
   assign bus.err_o          = err_q;
   assign bus.rvfi_valid     = pkt_q.valid;
   assign bus.rvfi_order     = pkt_q.order;
   assign bus.rvfi_insn      = pkt_q.insn;
   assign bus.rvfi_trap      = pkt_q.trap;
   assign bus.rvfi_halt      = pkt_q.halt;
   assign bus.rvfi_intr      = pkt_q.intr;
   assign bus.rvfi_mode      = pkt_q.mode;
   assign bus.rvfi_ixl       = pkt_q.ixl;
   assign bus.rvfi_rs1_addr  = pkt_q.rs1_addr;
   assign bus.rvfi_rs2_addr  = pkt_q.rs2_addr;
   assign bus.rvfi_rs3_addr  = 5'd0;
   assign bus.rvfi_rs1_rdata = pkt_q.rs1_rdata;
   assign bus.rvfi_rs2_rdata = pkt_q.rs2_rdata;
   assign bus.rvfi_rs3_rdata = 32'd0;
   assign bus.rvfi_rd_addr   = pkt_q.rd_addr;
   assign bus.rvfi_rd_wdata  = pkt_q.rd_wdata;
   assign bus.rvfi_pc_rdata  = pkt_q.pc_rdata;
   assign bus.rvfi_pc_wdata  = pkt_q.pc_wdata;
   assign bus.rvfi_mem_addr  = pkt_q.mem_addr;
   assign bus.rvfi_mem_rmask = pkt_q.mem_rmask;
   assign bus.rvfi_mem_wmask = pkt_q.mem_wmask;
   assign bus.rvfi_mem_rdata = pkt_q.mem_rdata;
   assign bus.rvfi_mem_wdata = pkt_q.mem_wdata;
endmodule

// File: tb/tb_miriscv_rvfi_tracker.sv
// tb_miriscv_rvfi_tracker: randomized checks of the RVFI tracker against a queue-based retirement model
module tb_miriscv_rvfi_tracker;
   localparam int DEPTH = 4;
   typedef struct packed {
      logic        valid;
      logic [63:0] order;
      logic [31:0] insn;
      logic        trap, halt, intr;
      logic [1:0]  mode, ixl;
      logic [4:0]  rs1a, rs2a, rs3a;
      logic [31:0] rs1d, rs2d, rs3d;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata, pc_rdata, pc_wdata, mem_addr;
      logic [3:0]  rmask, wmask;
      logic [31:0] mem_rdata, mem_wdata;
      logic        err;
   } pkt_t;
   typedef struct {
      logic [31:0] insn, pc, r1d, r2d;
      logic [4:0]  r1a, r2a;
   } ent_t;
   logic clk = 0;
   logic rst = 1;
   int tests = 0;
   int fails = 0;
   ent_t q[$];
   pkt_t e;
   logic [63:0] m_order;
   bit m_ipend, m_halted, m_err;
   always #5 clk = ~clk;
   miriscv_rvfi_tracker_if bus ();
   miriscv_rvfi_tracker #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic pkt_t dut_pkt();
      pkt_t p;
      p.valid = bus.rvfi_valid; p.order = bus.rvfi_order; p.insn = bus.rvfi_insn;
      p.trap = bus.rvfi_trap; p.halt = bus.rvfi_halt; p.intr = bus.rvfi_intr;
      p.mode = bus.rvfi_mode; p.ixl = bus.rvfi_ixl;
      p.rs1a = bus.rvfi_rs1_addr; p.rs2a = bus.rvfi_rs2_addr; p.rs3a = bus.rvfi_rs3_addr;
      p.rs1d = bus.rvfi_rs1_rdata; p.rs2d = bus.rvfi_rs2_rdata; p.rs3d = bus.rvfi_rs3_rdata;
      p.rd_addr = bus.rvfi_rd_addr; p.rd_wdata = bus.rvfi_rd_wdata;
      p.pc_rdata = bus.rvfi_pc_rdata; p.pc_wdata = bus.rvfi_pc_wdata;
      p.mem_addr = bus.rvfi_mem_addr; p.rmask = bus.rvfi_mem_rmask; p.wmask = bus.rvfi_mem_wmask;
      p.mem_rdata = bus.rvfi_mem_rdata; p.mem_wdata = bus.rvfi_mem_wdata;
      p.err = bus.err_o;
      return p;
   endfunction

   task automatic iss(bit v, logic [31:0] pc);
      bus.issue_valid_i = v; bus.issue_pc_i = pc; bus.issue_insn_i = $urandom;
      bus.issue_rs1_addr_i = 5'($urandom); bus.issue_rs2_addr_i = 5'($urandom);
      bus.issue_rs1_rdata_i = $urandom; bus.issue_rs2_rdata_i = $urandom;
   endtask

   task automatic ret(bit v, bit trap, logic [4:0] rd, bit halt);
      bus.retire_valid_i = v; bus.retire_trap_i = trap; bus.retire_rd_addr_i = rd; bus.halt_i = halt;
      bus.retire_rd_wdata_i = $urandom; bus.retire_pc_wdata_i = $urandom;
      bus.retire_mem_addr_i = $urandom; bus.retire_mem_rmask_i = 4'($urandom);
      bus.retire_mem_wmask_i = 4'($urandom); bus.retire_mem_rdata_i = $urandom;
      bus.retire_mem_wdata_i = $urandom;
   endtask

   task automatic idle();
      iss(0, 0); ret(0, 0, 0, 0); bus.flush_i = 0;
   endtask

   // Advance one clock; the model applies the retirement rules to the inputs present before the edge.
   task automatic tick();
      ent_t h, n;
      bit rdy;
      if (rst) begin
         q.delete(); e = '0; m_order = 0; m_ipend = 0; m_halted = 0; m_err = 0;
      end else begin
         rdy = q.size() < DEPTH && !bus.flush_i;
         e.valid = 0;
         if (bus.retire_valid_i) begin
            if (q.size() == 0 || m_halted) m_err = 1;
            else begin
               h = q.pop_front();
               e.valid = 1; e.order = m_order; m_order = m_order + 1;
               e.insn = h.insn; e.pc_rdata = h.pc;
               e.rs1a = h.r1a; e.rs2a = h.r2a; e.rs1d = h.r1d; e.rs2d = h.r2d;
               e.rs3a = 0; e.rs3d = 0; e.mode = 2'b11; e.ixl = 2'b01;
               e.trap = bus.retire_trap_i; e.halt = bus.halt_i; e.intr = m_ipend;
               m_ipend = bus.retire_trap_i; m_halted = bus.halt_i;
               e.rd_addr = bus.retire_rd_addr_i;
               e.rd_wdata = bus.retire_rd_addr_i == 0 ? 32'd0 : bus.retire_rd_wdata_i;
               e.pc_wdata = bus.retire_pc_wdata_i;
`ifdef MIRISCV_RVFI_MEM_EN
               e.mem_addr = bus.retire_mem_addr_i; e.rmask = bus.retire_mem_rmask_i;
               e.wmask = bus.retire_mem_wmask_i; e.mem_rdata = bus.retire_mem_rdata_i;
               e.mem_wdata = bus.retire_mem_wdata_i;
`endif
            end
         end
         if (bus.issue_valid_i && rdy) begin
            n.insn = bus.issue_insn_i; n.pc = bus.issue_pc_i;
            n.r1a = bus.issue_rs1_addr_i; n.r2a = bus.issue_rs2_addr_i;
            n.r1d = bus.issue_rs1_rdata_i; n.r2d = bus.issue_rs2_rdata_i;
            q.push_back(n);
         end
         if (bus.flush_i) q.delete();
         e.err = m_err;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      tick(); tick();
      tests++;
      if (dut_pkt() !== '0) begin fails++; $display("FAIL reset_in got %h want 0", dut_pkt()); end
      rst = 0;
      tick();
      tests++;
      if (dut_pkt() !== '0) begin fails++; $display("FAIL reset_out got %h want 0", dut_pkt()); end
      tests++;
      if (bus.issue_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.issue_ready_o); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 7; i++) begin
         iss(i < 3, 32'h80000000 + 32'(4 * i));
         ret(i >= 2 && i < 5, 0, 5'($urandom), 0);
         tick();
         tests++;
         if (dut_pkt() !== e) begin fails++; $display("FAIL basic c%0d got %h want %h", i, dut_pkt(), e); end
         if (i >= 2 && i < 5) begin
            tests++;
            if ({bus.rvfi_valid, bus.rvfi_order, bus.rvfi_pc_rdata} !== {1'b1, 64'(i - 2), 32'h80000000 + 32'(4 * (i - 2))}) begin
               fails++;
               $display("FAIL basic_pkt c%0d got v%b o%0d pc%h", i, bus.rvfi_valid, bus.rvfi_order, bus.rvfi_pc_rdata);
            end
         end
      end
      idle();
   endtask

   task automatic test_fill();
      // fill, retire+push at full (refused push), retire+push at 3, top up, then drain
      bit [1:0] plan [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
      for (int i = 0; i < 11; i++) begin
         iss(plan[i][1], 32'h1000 + 32'(4 * i));
         ret(plan[i][0], 0, 5'($urandom), 0);
         tick();
         tests++;
         if (dut_pkt() !== e) begin fails++; $display("FAIL fill c%0d got %h want %h", i, dut_pkt(), e); end
         tests++;
         if (bus.issue_ready_o !== (q.size() < DEPTH)) begin
            fails++; $display("FAIL fill_ready c%0d got %b want %b", i, bus.issue_ready_o, q.size() < DEPTH);
         end
         if (i == 3) begin
            tests++;
            if (bus.issue_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", bus.issue_ready_o); end
         end
      end
      idle();
   endtask

   task automatic test_rd_zero_trap();
      for (int i = 0; i < 6; i++) begin
         iss(i < 3, 32'h2000 + 32'(4 * i));
         ret(i >= 3, i == 4, i == 3 ? 5'd0 : 5'd7, 0);
         if (i == 3) bus.retire_rd_wdata_i = 32'hDEADBEEF;
         tick();
         tests++;
         if (dut_pkt() !== e) begin fails++; $display("FAIL rdtrap c%0d got %h want %h", i, dut_pkt(), e); end
      end
      idle();
   endtask

   task automatic test_trap_intr();
      for (int i = 0; i < 5; i++) begin
         iss(i < 3, 32'h3000 + 32'(4 * i));
         ret(i >= 3, i == 3, 5'd3, 0);
         tick();
         tests++;
         if (dut_pkt() !== e) begin fails++; $display("FAIL trapintr c%0d got %h want %h", i, dut_pkt(), e); end
         if (i >= 3) begin
            tests++;
            if ({bus.rvfi_trap, bus.rvfi_intr} !== (i == 3 ? 2'b10 : 2'b01)) begin
               fails++; $display("FAIL trap_intr c%0d got trap%b intr%b", i, bus.rvfi_trap, bus.rvfi_intr);
            end
         end
      end
      iss(0, 0); ret(1, 0, 5'd0, 0); bus.retire_rd_wdata_i = 32'hDEADBEEF;
      tick();
      tests++;
      if ({bus.rvfi_valid, bus.rvfi_rd_wdata} !== {1'b1, 32'd0}) begin
         fails++; $display("FAIL rd_zero got v%b %h want v1 0", bus.rvfi_valid, bus.rvfi_rd_wdata);
      end
      idle();
   endtask

   task automatic test_mem();
      iss(1, 32'h4000); tick();
      iss(0, 0); ret(1, 0, 5'd0, 0);
      bus.retire_mem_addr_i = 32'h1000; bus.retire_mem_wmask_i = 4'hf; bus.retire_mem_rmask_i = 4'h0;
      bus.retire_mem_wdata_i = 32'h55;
      tick();
      tests++;
      if (dut_pkt() !== e) begin fails++; $display("FAIL mem got %h want %h", dut_pkt(), e); end
      tests++;
`ifdef MIRISCV_RVFI_MEM_EN
      if ({bus.rvfi_mem_addr, bus.rvfi_mem_wmask, bus.rvfi_mem_rmask, bus.rvfi_mem_wdata} !== {32'h1000, 4'hf, 4'h0, 32'h55}) begin
`else
      if ({bus.rvfi_mem_addr, bus.rvfi_mem_wmask, bus.rvfi_mem_rmask, bus.rvfi_mem_wdata} !== 72'd0) begin
`endif
         fails++; $display("FAIL mem_fields got a%h w%h r%h d%h", bus.rvfi_mem_addr, bus.rvfi_mem_wmask, bus.rvfi_mem_rmask, bus.rvfi_mem_wdata);
      end
      idle();
   endtask

   task automatic test_random();
      logic [4:0] rd;
      for (int i = 0; i < 400; i++) begin
         rd = 5'($urandom);
         if ($urandom_range(0, 3) == 0) rd = 0;
         iss($urandom_range(0, 1) == 1, $urandom);
         ret($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, rd, 0);
         bus.flush_i = $urandom_range(0, 15) == 0;
         tick();
         tests++;
         if (dut_pkt() !== e) begin fails++; $display("FAIL random c%0d got %h want %h", i, dut_pkt(), e); end
      end
      idle();
   endtask

   task automatic test_flush();
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 5; i++) begin
         iss(i < 3, 32'h5000 + 32'(4 * i));
         ret(i >= 3, 0, 5'd1, 0);
         bus.flush_i = i == 3;
         tick();
         tests++;
         if (dut_pkt() !== e) begin fails++; $display("FAIL flush c%0d got %h want %h", i, dut_pkt(), e); end
         if (i >= 3) begin
            tests++;
            if ({bus.rvfi_valid, bus.err_o} !== (i == 3 ? 2'b10 : 2'b01)) begin
               fails++; $display("FAIL flush_err c%0d got v%b err%b", i, bus.rvfi_valid, bus.err_o);
            end
         end
      end
      idle();
   endtask

   task automatic test_halt();
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 4; i++) begin
         iss(i < 2, 32'h6000 + 32'(4 * i));
         ret(i >= 2, 0, 5'd2, i == 2);
         tick();
         tests++;
         if (dut_pkt() !== e) begin fails++; $display("FAIL halt c%0d got %h want %h", i, dut_pkt(), e); end
         if (i >= 2) begin
            tests++;
            if ({bus.rvfi_valid, bus.rvfi_halt, bus.err_o} !== (i == 2 ? 3'b110 : 3'b011)) begin
               fails++; $display("FAIL halt_flags c%0d got v%b h%b err%b", i, bus.rvfi_valid, bus.rvfi_halt, bus.err_o);
            end
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      rst = 1; tick(); rst = 0;
      iss(1, 32'h7000); tick(); iss(1, 32'h7004); tick(); iss(1, 32'h7008); ret(1, 0, 5'd4, 0); tick();
      iss(1, 32'h700c); ret(1, 0, 5'd4, 0); rst = 1;
      tick();
      rst = 0; idle();
      tests++;
      if (dut_pkt() !== '0) begin fails++; $display("FAIL rst_mid got %h want 0", dut_pkt()); end
      iss(1, 32'h8000); tick();
      iss(0, 0); ret(1, 0, 5'd5, 0); tick();
      tests++;
      if ({bus.rvfi_valid, bus.rvfi_order, bus.rvfi_pc_rdata, bus.err_o} !== {1'b1, 64'd0, 32'h8000, 1'b0}) begin
         fails++; $display("FAIL rst_order got v%b o%0d pc%h err%b", bus.rvfi_valid, bus.rvfi_order, bus.rvfi_pc_rdata, bus.err_o);
      end
      tests++;
      if (dut_pkt() !== e) begin fails++; $display("FAIL rst_model got %h want %h", dut_pkt(), e); end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_rd_zero_trap();
      test_trap_intr();
      test_mem();
      test_random();
      test_flush();
      test_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
